uart_tx_scheduler: RTL and testbench
====================================

// Module: uart_tx_scheduler
// PURPOSE
//  Shares one UART transmit serializer (Load/data_board in, status out) among NUM_REQ byte sources.
//  Round-robin arbitration with packet lock: a requester keeps the grant until its byte with req_last=1.
//  Drives the serializer Load strobe and holds it until the serializer starts a frame.
//  A timeout guards against a serializer that never starts. Sits between SoC byte producers
//  (core MMIO, debug) and the transmitter.
// PARAMETERS
//  NUM_REQ      4      number of requesters, >=2
//  DATA_W       8      byte width, matches serializer
//  TIMEOUT_CYC  65535  max clk_in cycles tx_load may stay high without tx_idle falling
// PORTS
//  clk_in     in   1                 system clock; single clock domain
//  reset      in   1                 synchronous, active-high
//  req_valid  in   NUM_REQ           requester i has a byte
//  req_data   in   NUM_REQ*DATA_W    byte of requester i at [i*DATA_W +: DATA_W]
//  req_last   in   NUM_REQ           byte ends requester i's packet (releases lock)
//  req_ready  out  NUM_REQ           one-hot accept; transfer = valid&ready same cycle
//  tx_data    out  DATA_W            byte to serializer, stable while tx_load or frame active
//  tx_load    out  1                 load request to serializer
//  tx_idle    in   1                 serializer status (1=idle); pre-synchronized to clk_in
//  grant_id   out  $clog2(NUM_REQ)   index of last/current granted requester
//  locked     out  1                 packet lock held by grant_id
//  busy       out  1                 state != IDLE
//  err_tmo    out  1                 1-cycle pulse on load timeout
// BEHAVIOUR
//  Reset (sync): state=IDLE, tx_load=0, tx_data=0, grant_id=0, locked=0, err_tmo=0, rr_ptr=0, tmo_cnt=0.
//   req_ready=0 while reset=1. Reset mid-frame drops tx_load next edge; no grant until tx_idle=1.
//  FSM states: IDLE, LOAD, WAIT_DONE.
//  IDLE: when tx_idle=1, pick winner:
//   locked=1: only grant_id eligible; others wait even if valid.
//   else: first valid index scanning rr_ptr, rr_ptr+1, ... mod NUM_REQ.
//   req_ready[winner]=1 combinationally that cycle (only if its valid=1).
//   On transfer: tx_data<=byte, grant_id<=winner, locked<=~req_last[winner], tmo_cnt<=0, ->LOAD.
//   If req_last=1: rr_ptr<=(winner+1) mod NUM_REQ. No valid eligible: stay IDLE, ready all 0.
//  LOAD: tx_load=1 (registered; high first cycle after acceptance). tmo_cnt increments each cycle.
//   tx_idle=0 -> tx_load<=0, ->WAIT_DONE.
//   tmo_cnt==TIMEOUT_CYC-1 with tx_idle still 1: tx_load<=0, err_tmo pulse, locked<=0,
//   rr_ptr<=(grant_id+1) mod NUM_REQ, ->IDLE; byte dropped.
//   tx_idle falling on the timeout cycle counts as success (no error).
//  WAIT_DONE: tx_load=0; tx_idle=1 -> IDLE. Next grant no earlier than the cycle after return.
//  Throughput: at most one byte per serializer frame; no byte buffered beyond tx_data.
//  req_ready is never asserted outside IDLE; at most one bit set.
//  Requester dropping valid while locked: lock persists; arbiter waits indefinitely for it.
//  tmo_cnt width $clog2(TIMEOUT_CYC+1); saturation unreachable since LOAD exits at limit.
// TESTING
//  1 Single byte: req_valid=0001, data0=8'hA5, last=1, model serializer idles 3 cyc after load
//    -> ready0 one cycle, tx_data=A5, tx_load high until tx_idle=0, busy low after tx_idle=1.
//  2 Round robin: all 4 valid, last=1 each, 8 bytes -> grant order 0,1,2,3,0,1,2,3.
//  3 Packet lock: req1 sends 3 bytes (last on 3rd) while req0,req2 valid
//    -> grants 1,1,1 then 2, then 0; locked=1 during first two gaps.
//  4 Timeout: TIMEOUT_CYC=16, tx_idle stuck 1 -> tx_load high 16 cyc, err_tmo pulse,
//    locked cleared, next grant rotates.
//  5 Reset in WAIT_DONE with tx_idle=0 -> tx_load=0, outputs at reset values;
//    no req_ready until tx_idle returns to 1.
//  6 Boundary: rr_ptr=3, only req0 valid -> wraps, grants 0; tx_idle falling on the last
//    timeout cycle -> no err_tmo.

Source files
------------

// File: rtl/uart_tx_scheduler_if.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler_if
// Bundles the byte-request bus from NUM_REQ producers together with the load
// handshake towards a single UART transmit serializer.
//
//   req_valid [NUM_REQ]         producer i has a byte
//   req_data  [NUM_REQ*DATA_W]  byte of producer i at [i*DATA_W +: DATA_W]
//   req_last  [NUM_REQ]         byte closes producer i's packet
//   req_ready [NUM_REQ]         one-hot accept from the scheduler
//   tx_data   [DATA_W]          byte presented to the serializer
//   tx_load                     load request to the serializer
//   tx_idle                     serializer status, 1 = idle
//
// Modports:
//   slave  - the scheduler (accepts bytes, drives the serializer)
//   master - the environment (producers plus serializer)
// -----------------------------------------------------------------------------
interface uart_tx_scheduler_if #(
   parameter int NUM_REQ = 4,
   parameter int DATA_W  = 8
);
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic [NUM_REQ-1:0]        req_ready;
   logic [DATA_W-1:0]         tx_data;
   logic                      tx_load;
   logic                      tx_idle;

   modport slave (
      input  req_valid, req_data, req_last, tx_idle,
      output req_ready, tx_data, tx_load
   );

   modport master (
      output req_valid, req_data, req_last, tx_idle,
      input  req_ready, tx_data, tx_load
   );
endinterface

// File: rtl/uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// uart_tx_scheduler
// Shares one UART transmit serializer among NUM_REQ byte producers.
// Round-robin arbitration with packet lock: the granted producer keeps the
// grant until it hands over a byte with req_last=1. The accepted byte is held
// in tx_data and tx_load is raised until the serializer leaves idle. If the
// serializer never starts within TIMEOUT_CYC cycles the byte is dropped, the
// lock is released and err_tmo pulses for one cycle.
//
// Ports:
//   clk_in     in   system clock
//   reset      in   synchronous, active-high
//   bus        slave modport of uart_tx_scheduler_if (requests + serializer)
//   grant_id   out  index of the last/current granted producer
//   locked     out  packet lock held by grant_id
//   busy       out  scheduler not in IDLE
//   err_tmo    out  one-cycle pulse when a load times out
//   dbg_state  out  current FSM state (state_t encoding)
//
// Handshake: a byte moves from producer i when req_valid[i] and req_ready[i]
// are both high at the same rising edge. req_ready is one-hot, combinational,
// only ever raised in IDLE while the serializer is idle and never during
// reset; the producer must hold data/last stable while valid is high.
// -----------------------------------------------------------------------------
module uart_tx_scheduler #(
   parameter int NUM_REQ     = 4,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 65535,
   localparam int ID_W       = $clog2(NUM_REQ),
   localparam int TMO_W      = $clog2(TIMEOUT_CYC + 1)
) (
   input  logic                  clk_in,
   input  logic                  reset,
   uart_tx_scheduler_if.slave    bus,
   output logic [ID_W-1:0]       grant_id,
   output logic                  locked,
   output logic                  busy,
   output logic                  err_tmo,
   output logic [1:0]            dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE      = 2'd0,
      S_LOAD      = 2'd1,
      S_WAIT_DONE = 2'd2
   } state_t;

   state_t             state_q,    state_d;
   logic               tx_load_q,  tx_load_d;
   logic [DATA_W-1:0]  tx_data_q,  tx_data_d;
   logic [ID_W-1:0]    grant_id_q, grant_id_d;
   logic               locked_q,   locked_d;
   logic               err_tmo_q,  err_tmo_d;
   logic [ID_W-1:0]    rr_ptr_q,   rr_ptr_d;
   logic [TMO_W-1:0]   tmo_cnt_q,  tmo_cnt_d;

   logic [NUM_REQ-1:0] req_ready;
   logic               win_found;
   logic [ID_W-1:0]    win_id;
   logic [ID_W-1:0]    cand;

   // (base + ofs) mod NUM_REQ; ofs is always below NUM_REQ.
   function automatic logic [ID_W-1:0] wrap_add(input logic [ID_W-1:0] base,
                                                input int ofs);
      int sum;
      sum = int'(base) + ofs;
      if (sum >= NUM_REQ) sum = sum - NUM_REQ;
      return ID_W'(sum);
   endfunction

   // Winner selection. Under lock only the holder may win. Otherwise the scan
   // runs from the highest offset down so the last hit is the first valid
   // index at or after rr_ptr in round-robin order.
   always_comb begin
      win_found = 1'b0;
      win_id    = '0;
      cand      = '0;
      if (locked_q) begin
         win_found = bus.req_valid[grant_id_q];
         win_id    = grant_id_q;
      end else begin
         for (int i = NUM_REQ - 1; i >= 0; i--) begin
            cand = wrap_add(rr_ptr_q, i);
            if (bus.req_valid[cand]) begin
               win_found = 1'b1;
               win_id    = cand;
            end
         end
      end
   end

   always_comb begin
      state_d    = state_q;
      tx_load_d  = tx_load_q;
      tx_data_d  = tx_data_q;
      grant_id_d = grant_id_q;
      locked_d   = locked_q;
      err_tmo_d  = 1'b0;
      rr_ptr_d   = rr_ptr_q;
      tmo_cnt_d  = tmo_cnt_q;
      req_ready  = '0;

      case (state_q)
         S_IDLE: begin
            if (!reset && bus.tx_idle && win_found) begin
               req_ready[win_id] = 1'b1;
               tx_data_d  = bus.req_data[int'(win_id)*DATA_W +: DATA_W];
               grant_id_d = win_id;
               locked_d   = ~bus.req_last[win_id];
               tmo_cnt_d  = '0;
               tx_load_d  = 1'b1;
               state_d    = S_LOAD;
               if (bus.req_last[win_id]) rr_ptr_d = wrap_add(win_id, 1);
            end
         end

         S_LOAD: begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
            // A serializer that starts on the final allowed cycle still wins.
            if (!bus.tx_idle) begin
               tx_load_d = 1'b0;
               state_d   = S_WAIT_DONE;
            end else if (tmo_cnt_q == TMO_W'(TIMEOUT_CYC - 1)) begin
               tx_load_d = 1'b0;
               err_tmo_d = 1'b1;
               locked_d  = 1'b0;
               rr_ptr_d  = wrap_add(grant_id_q, 1);
               state_d   = S_IDLE;
            end
         end

         S_WAIT_DONE: begin
            if (bus.tx_idle) state_d = S_IDLE;
         end

         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_in) begin
      if (reset) begin
         state_q    <= S_IDLE;
         tx_load_q  <= 1'b0;
         tx_data_q  <= '0;
         grant_id_q <= '0;
         locked_q   <= 1'b0;
         err_tmo_q  <= 1'b0;
         rr_ptr_q   <= '0;
         tmo_cnt_q  <= '0;
      end else begin
         state_q    <= state_d;
         tx_load_q  <= tx_load_d;
         tx_data_q  <= tx_data_d;
         grant_id_q <= grant_id_d;
         locked_q   <= locked_d;
         err_tmo_q  <= err_tmo_d;
         rr_ptr_q   <= rr_ptr_d;
         tmo_cnt_q  <= tmo_cnt_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.tx_data   = tx_data_q;
   assign bus.tx_load   = tx_load_q;
   assign grant_id      = grant_id_q;
   assign locked        = locked_q;
   assign busy          = (state_q != S_IDLE);
   assign err_tmo       = err_tmo_q;
   assign dbg_state     = state_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_scheduler
// Bench for uart_tx_scheduler (NUM_REQ=4, DATA_W=8, TIMEOUT_CYC=16).
// A behavioural serializer answers tx_load either automatically (start delay
// and frame length, optionally randomized) or follows a manually driven idle
// level. Inputs change 1 time unit after the rising edge, outputs are sampled
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_scheduler;
   localparam int NR  = 4;
   localparam int DW  = 8;
   localparam int TMO = 16;

   logic       clk_in = 1'b0;
   logic       reset  = 1'b1;
   logic [1:0] grant_id;
   logic       locked;
   logic       busy;
   logic       err_tmo;
   logic [1:0] dbg_state;

   uart_tx_scheduler_if #(.NUM_REQ(NR), .DATA_W(DW)) ifc ();

   uart_tx_scheduler #(.NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYC(TMO)) dut (
      .clk_in    (clk_in),
      .reset     (reset),
      .bus       (ifc),
      .grant_id  (grant_id),
      .locked    (locked),
      .busy      (busy),
      .err_tmo   (err_tmo),
      .dbg_state (dbg_state)
   );

   // ---------------- clock ----------------
   always #5 clk_in = ~clk_in;

   // ---------------- bookkeeping ----------------
   int n_checks = 0;
   int n_errors = 0;

   // serializer model controls
   bit   ser_auto = 1'b0;
   bit   ser_rand = 1'b0;
   logic man_idle = 1'b1;
   int   ser_dly  = 3;
   int   ser_len  = 4;
   int   ser_wait = 0;
   int   ser_busy = 0;

   // scoreboard: {requester id, byte} in expected acceptance order
   logic [9:0] exp_q[$];
   logic [8:0] src_q[NR][$];   // {last, byte} per requester
   logic [8:0] mdl_q[NR][$];

   typedef struct {
      logic [3:0] valid;
      logic [3:0] last;
      logic [3:0] exp_ready;
      logic [1:0] exp_grant;
      logic       exp_locked;
   } vec_t;
   vec_t tbl[19];

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   // ---------------- serializer model ----------------
   initial begin
      ifc.tx_idle = 1'b1;
      forever begin
         @(posedge clk_in);
         #2;
         if (ser_auto) begin
            if (ser_busy > 0) begin
               ser_busy--;
               if (ser_busy == 0) ifc.tx_idle = 1'b1;
            end else if (ifc.tx_load) begin
               if (ser_wait < ser_dly) ser_wait++;
               else begin
                  ifc.tx_idle = 1'b0;
                  ser_busy    = ser_len;
                  ser_wait    = 0;
                  if (ser_rand) begin
                     ser_dly = $urandom_range(0, 4);
                     ser_len = $urandom_range(1, 5);
                  end
               end
            end
         end else begin
            ifc.tx_idle = man_idle;
            ser_wait    = 0;
            ser_busy    = 0;
         end
      end
   end

   // ---------------- watchdog ----------------
   initial begin
      #500000;
      $display("FAIL watchdog: got still running, expected finished");
      $fatal(1, "watchdog expired");
   end

   // ---------------- driver helpers ----------------
   task automatic do_reset();
      ser_auto      = 1'b0;
      man_idle      = 1'b1;
      reset         = 1'b1;
      ifc.req_valid = '0;
      ifc.req_last  = '0;
      tick();
      tick();
      reset = 1'b0;
   endtask

   // Wait (bounded) until the scheduler is in IDLE with the serializer idle.
   task automatic wait_idle(input int budget);
      int n;
      n = 0;
      @(negedge clk_in);
      while ((busy || !ifc.tx_idle) && n < budget) begin
         tick();
         @(negedge clk_in);
         n++;
      end
      check("wait_idle_budget", (n < budget), 1'b1);
      tick();
   endtask

   task automatic run_random();
      int total, ptr, lk, w, xfers, budget, npk, len;
      bit pend;
      logic [9:0] pend_v;
      logic [8:0] e;
      total = 0;
      exp_q.delete();
      for (int r = 0; r < NR; r++) begin
         src_q[r].delete();
         mdl_q[r].delete();
         npk = (r == 0) ? $urandom_range(1, 3) : $urandom_range(0, 3);
         for (int p = 0; p < npk; p++) begin
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++) begin
               e = {(b == len - 1), 8'($urandom)};
               src_q[r].push_back(e);
               mdl_q[r].push_back(e);
               total++;
            end
         end
      end
      // reference: transaction-level arbitration from reset (pointer 0, no lock)
      ptr = 0;
      lk  = -1;
      for (int n = 0; n < total; n++) begin
         w = -1;
         if (lk >= 0) w = lk;
         else begin
            for (int k = 0; k < NR && w < 0; k++)
               if (mdl_q[(ptr + k) % NR].size() != 0) w = (ptr + k) % NR;
         end
         if (w < 0) break;
         e = mdl_q[w].pop_front();
         exp_q.push_back({2'(w), e[7:0]});
         if (e[8]) begin
            lk  = -1;
            ptr = (w + 1) % NR;
         end else lk = w;
      end
      // apply: each requester presents its queue head continuously
      xfers  = 0;
      budget = 0;
      pend   = 1'b0;
      pend_v = '0;
      while (budget < 4000 && (exp_q.size() != 0 || pend || busy)) begin
         for (int r = 0; r < NR; r++) begin
            if (src_q[r].size() != 0) begin
               e = src_q[r][0];
               ifc.req_valid[r]          = 1'b1;
               ifc.req_last[r]           = e[8];
               ifc.req_data[r*DW +: DW]  = e[7:0];
            end else begin
               ifc.req_valid[r] = 1'b0;
               ifc.req_last[r]  = 1'b0;
            end
         end
         @(negedge clk_in);
         if (pend) begin
            check("rand_load_high", ifc.tx_load, 1'b1);
            check("rand_load_word", {grant_id, ifc.tx_data}, pend_v);
            pend = 1'b0;
         end
         check("rand_ready_onehot", $onehot0(ifc.req_ready), 1'b1);
         check("rand_ready_busy", (busy && (ifc.req_ready != 0)), 1'b0);
         if ((ifc.req_ready & ifc.req_valid) != 0) begin
            w = 0;
            for (int k = 0; k < NR; k++) if (ifc.req_ready[k]) w = k;
            pend_v = {2'(w), ifc.req_data[w*DW +: DW]};
            pend   = 1'b1;
            xfers++;
            if (exp_q.size() != 0) check("rand_order", pend_v, exp_q.pop_front());
            e = src_q[w].pop_front();
         end
         tick();
         budget++;
      end
      ifc.req_valid = '0;
      check("rand_budget", (budget < 4000), 1'b1);
      check("rand_xfer_count", xfers, total);
   endtask

   // ---------------- main sequence ----------------
   initial begin : main
      int n;
      int errs_seen;

      tbl[0]  = '{4'hF, 4'hF, 4'h2, 2'd1, 1'b0};
      tbl[1]  = '{4'hF, 4'hF, 4'h4, 2'd2, 1'b0};
      tbl[2]  = '{4'hF, 4'hF, 4'h8, 2'd3, 1'b0};
      tbl[3]  = '{4'hF, 4'hF, 4'h1, 2'd0, 1'b0};
      tbl[4]  = '{4'hF, 4'hF, 4'h2, 2'd1, 1'b0};
      tbl[5]  = '{4'hF, 4'hF, 4'h4, 2'd2, 1'b0};
      tbl[6]  = '{4'hF, 4'hF, 4'h8, 2'd3, 1'b0};
      tbl[7]  = '{4'hF, 4'hF, 4'h1, 2'd0, 1'b0};
      tbl[8]  = '{4'h7, 4'h0, 4'h2, 2'd1, 1'b1};   // req1 packet, byte 1
      tbl[9]  = '{4'h7, 4'h0, 4'h2, 2'd1, 1'b1};   // byte 2, others still wait
      tbl[10] = '{4'h7, 4'h2, 4'h2, 2'd1, 1'b0};   // last byte releases
      tbl[11] = '{4'h5, 4'h5, 4'h4, 2'd2, 1'b0};
      tbl[12] = '{4'h5, 4'h5, 4'h1, 2'd0, 1'b0};   // pointer 3 wraps to 0
      tbl[13] = '{4'h8, 4'h0, 4'h8, 2'd3, 1'b1};
      tbl[14] = '{4'h7, 4'h7, 4'h0, 2'd3, 1'b1};   // holder absent: nobody granted
      tbl[15] = '{4'hF, 4'h8, 4'h8, 2'd3, 1'b0};
      tbl[16] = '{4'h4, 4'h4, 4'h4, 2'd2, 1'b0};
      tbl[17] = '{4'h1, 4'h1, 4'h1, 2'd0, 1'b0};   // pointer 3, only req0 valid
      tbl[18] = '{4'h0, 4'h0, 4'h0, 2'd0, 1'b0};

      // reset values, and no ready while reset is high
      ifc.req_valid = '0;
      ifc.req_last  = '0;
      ifc.req_data  = '0;
      tick();
      tick();
      ifc.req_valid = 4'hF;
      ifc.req_last  = 4'hF;
      @(negedge clk_in);
      check("rst_ready", ifc.req_ready, 4'h0);
      check("rst_tx_load", ifc.tx_load, 1'b0);
      check("rst_tx_data", ifc.tx_data, 8'h00);
      check("rst_grant", grant_id, 2'd0);
      check("rst_locked", locked, 1'b0);
      check("rst_busy", busy, 1'b0);
      check("rst_err", err_tmo, 1'b0);
      tick();
      ifc.req_valid = '0;
      ifc.req_last  = '0;
      reset         = 1'b0;
      tick();

      // single byte through an auto serializer (start 3 cycles after load)
      ser_auto = 1'b1;
      ser_rand = 1'b0;
      ser_dly  = 3;
      ser_len  = 4;
      ifc.req_data[7:0] = 8'hA5;
      ifc.req_valid = 4'b0001;
      ifc.req_last  = 4'b0001;
      @(negedge clk_in);
      check("t1_ready", ifc.req_ready, 4'b0001);
      tick();
      ifc.req_valid = '0;
      @(negedge clk_in);
      check("t1_tx_data", ifc.tx_data, 8'hA5);
      check("t1_busy", busy, 1'b1);
      check("t1_grant", grant_id, 2'd0);
      check("t1_ready_off", ifc.req_ready, 4'h0);
      n = 0;
      while (ifc.tx_load && n < 20) begin
         n++;
         tick();
         @(negedge clk_in);
      end
      check("t1_load_cycles", n, 4);
      check("t1_idle_at_drop", ifc.tx_idle, 1'b0);
      check("t1_busy_frame", busy, 1'b1);
      tick();
      wait_idle(40);

      // table: round robin, packet lock, wrap, empty
      for (int i = 0; i < 19; i++) begin
         ifc.req_valid = tbl[i].valid;
         ifc.req_last  = tbl[i].last;
         for (int r = 0; r < NR; r++) ifc.req_data[r*DW +: DW] = 8'(r * 16 + i);
         @(negedge clk_in);
         check($sformatf("tbl%0d_ready", i), ifc.req_ready, tbl[i].exp_ready);
         tick();
         ifc.req_valid = '0;
         @(negedge clk_in);
         check($sformatf("tbl%0d_busy", i), busy, (tbl[i].exp_ready != 0));
         check($sformatf("tbl%0d_grant", i), grant_id, tbl[i].exp_grant);
         check($sformatf("tbl%0d_locked", i), locked, tbl[i].exp_locked);
         if (tbl[i].exp_ready != 0) begin
            check($sformatf("tbl%0d_tx_data", i), ifc.tx_data, 8'(tbl[i].exp_grant * 16 + i));
            check($sformatf("tbl%0d_load", i), ifc.tx_load, 1'b1);
         end
         tick();
         wait_idle(60);
         check($sformatf("tbl%0d_locked_gap", i), locked, tbl[i].exp_locked);
      end

      // timeout: serializer stuck idle, locked packet from req1
      ser_auto      = 1'b0;
      man_idle      = 1'b1;
      ifc.req_valid = 4'b0010;
      ifc.req_last  = 4'b0000;
      @(negedge clk_in);
      check("t4_ready", ifc.req_ready, 4'b0010);
      tick();
      ifc.req_valid = '0;
      @(negedge clk_in);
      check("t4_locked_on", locked, 1'b1);
      n = 0;
      errs_seen = 0;
      while (ifc.tx_load && n < 40) begin
         if (err_tmo) errs_seen++;
         n++;
         tick();
         @(negedge clk_in);
      end
      check("t4_load_cycles", n, TMO);
      check("t4_err_early", errs_seen, 0);
      check("t4_err_pulse", err_tmo, 1'b1);
      check("t4_locked_clr", locked, 1'b0);
      check("t4_busy", busy, 1'b0);
      tick();
      @(negedge clk_in);
      check("t4_err_one_cycle", err_tmo, 1'b0);
      tick();
      ser_auto      = 1'b1;
      ifc.req_valid = 4'b0111;
      ifc.req_last  = 4'b0111;
      @(negedge clk_in);
      check("t4_rotate", ifc.req_ready, 4'b0100);
      tick();
      ifc.req_valid = '0;
      wait_idle(60);

      // reset while the serializer is mid-frame
      ser_auto      = 1'b0;
      man_idle      = 1'b1;
      ifc.req_valid = 4'b0001;
      ifc.req_last  = 4'b0001;
      @(negedge clk_in);
      check("t5_ready", ifc.req_ready, 4'b0001);
      tick();
      ifc.req_valid = '0;
      man_idle      = 1'b0;
      @(negedge clk_in);
      check("t5_load", ifc.tx_load, 1'b1);
      tick();
      @(negedge clk_in);
      check("t5_wait_load", ifc.tx_load, 1'b0);
      check("t5_wait_busy", busy, 1'b1);
      tick();
      reset         = 1'b1;
      ifc.req_valid = 4'hF;
      ifc.req_last  = 4'hF;
      @(negedge clk_in);
      check("t5_ready_in_rst", ifc.req_ready, 4'h0);
      tick();
      @(negedge clk_in);
      check("t5_rst_load", ifc.tx_load, 1'b0);
      check("t5_rst_data", ifc.tx_data, 8'h00);
      check("t5_rst_grant", grant_id, 2'd0);
      check("t5_rst_busy", busy, 1'b0);
      check("t5_rst_locked", locked, 1'b0);
      check("t5_rst_err", err_tmo, 1'b0);
      tick();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk_in);
         check("t5_no_grant", ifc.req_ready, 4'h0);
         tick();
      end
      man_idle = 1'b1;
      @(negedge clk_in);
      check("t5_grant_after", ifc.req_ready, 4'b0001);
      tick();
      ifc.req_valid = '0;
      ser_auto      = 1'b1;
      wait_idle(60);

      // serializer starts on the very last allowed cycle: no error
      ser_auto      = 1'b0;
      man_idle      = 1'b1;
      ifc.req_valid = 4'b0010;
      ifc.req_last  = 4'b0010;
      @(negedge clk_in);
      check("t6_ready", ifc.req_ready, 4'b0010);
      tick();
      ifc.req_valid = '0;
      n = 0;
      errs_seen = 0;
      repeat (TMO - 1) begin
         @(negedge clk_in);
         if (ifc.tx_load) n++;
         if (err_tmo) errs_seen++;
         tick();
      end
      man_idle = 1'b0;
      @(negedge clk_in);
      check("t6_load_cycles", n, TMO - 1);
      check("t6_load_last", ifc.tx_load, 1'b1);
      tick();
      @(negedge clk_in);
      check("t6_load_drop", ifc.tx_load, 1'b0);
      check("t6_no_err", err_tmo | (errs_seen != 0), 1'b0);
      check("t6_busy", busy, 1'b1);
      tick();
      man_idle = 1'b1;
      wait_idle(40);

      // randomized packets against the transaction-level model
      for (int round = 0; round < 3; round++) begin
         do_reset();
         ser_rand = 1'b1;
         ser_auto = 1'b1;
         run_random();
      end

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
